// File: rtl/vpp_scan_ctrl_pkg.sv
// Shared types and constants for the peak-to-peak channel scanner.
package vpp_scan_ctrl_pkg;

   // Scanner FSM states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_REPORT = 2'd3
   } state_e;

   // Width of one ADC sample and of the peak-to-peak result
   localparam int SAMPLE_W = 8;

   // Default timing: 250000 clk per sample, 10 samples per window, 1000 clk settle
   localparam int DEF_SAMPLE_DIV  = 250000;
   localparam int DEF_WIN_SAMPLES = 10;
   localparam int DEF_SETTLE_CYC  = 1000;

   // Counter width for a counter running 0..n-1; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vpp_scan_ctrl_minmax_track.sv
// Running max/min tracker for one measurement window.
// range reflects the window including the sample presented this cycle, so
// the final sample of a window can be folded into the result on the same edge.
module minmax_track
   import vpp_scan_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                update,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [SAMPLE_W-1:0] range
);

   logic [SAMPLE_W-1:0] max_q, max_d;
   logic [SAMPLE_W-1:0] min_q, min_d;

   // Next max/min: load restarts the window, update widens it on strict extremes
   always_comb begin
      max_d = max_q;
      min_d = min_q;
      if (load) begin
         max_d = sample;
         min_d = sample;
      end else if (update) begin
         if (sample > max_q) max_d = sample;
         if (sample < min_q) min_d = sample;
      end
   end

   // max >= min always holds, so the difference never underflows
   assign range = max_d - min_d;

   // Max/min registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         min_q <= '0;
      end else begin
         max_q <= max_d;
         min_q <= min_d;
      end
   end

endmodule

// File: rtl/vpp_scan_ctrl.sv
// Multiplexed-channel peak-to-peak scanner: settle after each channel switch,
// take a window of divided-down samples, report max-min with a valid/ready
// handshake, then advance to the next channel.
module vpp_scan_ctrl
   import vpp_scan_ctrl_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
   parameter int WIN_SAMPLES = DEF_WIN_SAMPLES,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [SAMPLE_W-1:0]       ch_dec,
   output logic [$clog2(NUM_CH)-1:0] ch_sel,
   output logic [SAMPLE_W-1:0]       vpp_out,
   output logic [$clog2(NUM_CH)-1:0] res_ch,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      busy
);

   localparam int CH_W     = $clog2(NUM_CH);
   localparam int DIV_W    = cnt_w(SAMPLE_DIV);
   localparam int SETTLE_W = cnt_w(SETTLE_CYC);
   localparam int SAMP_W   = cnt_w(WIN_SAMPLES);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
   logic [SAMPLE_W-1:0] vpp_q, vpp_d;
   logic [CH_W-1:0]     res_ch_q, res_ch_d;
   logic                res_valid_q, res_valid_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [SAMP_W-1:0]   samp_q, samp_d;

   logic                tick;
   logic                last_sample;
   logic                mm_load;
   logic                mm_update;
   logic [SAMPLE_W-1:0] mm_range;

   assign tick        = (state_q == ST_SAMPLE) && (div_q == DIV_W'(SAMPLE_DIV - 1));
   assign last_sample = (samp_q == SAMP_W'(WIN_SAMPLES - 1));
   // A falling enable discards the window, so the tracker is not touched then
   assign mm_load     = tick && enable && (samp_q == '0);
   assign mm_update   = tick && enable && (samp_q != '0);

   minmax_track u_minmax (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (mm_load),
      .update (mm_update),
      .sample (ch_dec),
      .range  (mm_range)
   );

   // Next-state and datapath updates; every register holds by default
   always_comb begin
      state_d     = state_q;
      ch_sel_d    = ch_sel_q;
      vpp_d       = vpp_q;
      res_ch_d    = res_ch_q;
      res_valid_d = res_valid_q;
      div_d       = div_q;
      settle_d    = settle_q;
      samp_d      = samp_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
               state_d = ST_SAMPLE;
               div_d   = '0;
               samp_d  = '0;
            end else begin
               settle_d = settle_q + SETTLE_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               div_d = tick ? '0 : div_q + DIV_W'(1);
               if (tick) begin
                  if (last_sample) begin
                     vpp_d       = mm_range;
                     res_ch_d    = ch_sel_q;
                     res_valid_d = 1'b1;
                     state_d     = ST_REPORT;
                  end else begin
                     samp_d = samp_q + SAMP_W'(1);
                  end
               end
            end
         end
         ST_REPORT: begin
            // Result is held regardless of enable until it has been accepted
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               ch_sel_d    = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
               if (enable) begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ch_sel_q    <= '0;
         vpp_q       <= '0;
         res_ch_q    <= '0;
         res_valid_q <= 1'b0;
         div_q       <= '0;
         settle_q    <= '0;
         samp_q      <= '0;
      end else begin
         state_q     <= state_d;
         ch_sel_q    <= ch_sel_d;
         vpp_q       <= vpp_d;
         res_ch_q    <= res_ch_d;
         res_valid_q <= res_valid_d;
         div_q       <= div_d;
         settle_q    <= settle_d;
         samp_q      <= samp_d;
      end
   end

   assign ch_sel    = ch_sel_q;
   assign vpp_out   = vpp_q;
   assign res_ch    = res_ch_q;
   assign res_valid = res_valid_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
